// File: rtl/lives_pkg.sv
// Shared types and sizing helper for the life-tracking block and its HUD encoder.
package lives_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        GRACE     = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    // Smallest bit width able to hold every value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/lives_thermo_enc.sv
// Combinational HUD encoder: thermometer of the life count plus the blinking
// icon of the life just lost while the grace window is running.
module lives_thermo_enc
    import lives_pkg::*;
#(
    parameter int MAX_LIVES = 8,
    parameter int CNT_W     = cnt_width(MAX_LIVES)
) (
    input  logic [CNT_W-1:0]     i_count,
    input  logic [CNT_W-1:0]     i_lost_idx,
    input  logic                 i_blink_on,
    input  logic                 i_grace,
    output logic [MAX_LIVES-1:0] o_enable
);

    logic w_blink_vis;

    // The lost icon only shows while it still sits above the count; a bonus
    // that re-covers it makes it part of the solid thermometer instead.
    assign w_blink_vis = i_grace && i_blink_on && (i_lost_idx >= i_count);

    always_comb begin
        o_enable = '0;
        for (int i = 0; i < MAX_LIVES; i++) begin
            o_enable[i] = (CNT_W'(i) < i_count) ||
                          (w_blink_vis && (CNT_W'(i) == i_lost_idx));
        end
    end

endmodule

// File: rtl/lives_manager.sv
// Life counter with hit/bonus handling, frame-counted grace window after a hit,
// registered HUD icon enables and a game-over level for the game controller.
module lives_manager
    import lives_pkg::*;
#(
    parameter int MAX_LIVES    = 8,
    parameter int INIT_LIVES   = 3,
    parameter int GRACE_FRAMES = 60,
    parameter int BLINK_FRAMES = 8,
    parameter int CNT_W        = cnt_width(MAX_LIVES)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 newGame,
    input  logic                 hitPulse,
    input  logic                 bonusPulse,
    output logic [CNT_W-1:0]     livesCount,
    output logic [MAX_LIVES-1:0] enableLives,
    output logic                 invulnerable,
    output logic                 gameOver
);

    localparam int GRACE_W = cnt_width(GRACE_FRAMES);
    localparam int BLINK_W = cnt_width(BLINK_FRAMES);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_lives;
    logic [CNT_W-1:0]       r_lost_idx;
    logic [GRACE_W-1:0]     r_grace_cnt;
    logic [BLINK_W-1:0]     r_blink_cnt;
    logic                   r_blink_on;
    logic [MAX_LIVES-1:0]   r_enable;
    logic                   r_invulnerable;
    logic                   r_game_over;

    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_lives_nxt;
    logic [CNT_W-1:0]       w_lost_nxt;
    logic [GRACE_W-1:0]     w_grace_nxt;
    logic [BLINK_W-1:0]     w_blink_cnt_nxt;
    logic                   w_blink_on_nxt;
    logic [MAX_LIVES-1:0]   w_enable_nxt;
    logic                   w_inv_nxt;
    logic                   w_go_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_W'(MAX_LIVES)) ? v : v + CNT_W'(1);
    endfunction

    // State and datapath registers; outputs are registered from next-state values
    // so every event is visible exactly one cycle later.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state        <= PLAY;
            r_lives        <= CNT_W'(INIT_LIVES);
            r_lost_idx     <= '0;
            r_grace_cnt    <= '0;
            r_blink_cnt    <= '0;
            r_blink_on     <= 1'b1;
            r_invulnerable <= 1'b0;
            r_game_over    <= 1'b0;
            for (int i = 0; i < MAX_LIVES; i++) begin
                r_enable[i] <= (i < INIT_LIVES);
            end
        end else begin
            r_state        <= w_state_nxt;
            r_lives        <= w_lives_nxt;
            r_lost_idx     <= w_lost_nxt;
            r_grace_cnt    <= w_grace_nxt;
            r_blink_cnt    <= w_blink_cnt_nxt;
            r_blink_on     <= w_blink_on_nxt;
            r_enable       <= w_enable_nxt;
            r_invulnerable <= w_inv_nxt;
            r_game_over    <= w_go_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_lives_nxt     = r_lives;
        w_lost_nxt      = r_lost_idx;
        w_grace_nxt     = r_grace_cnt;
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_on_nxt  = r_blink_on;
        if (newGame) begin
            w_state_nxt     = PLAY;
            w_lives_nxt     = CNT_W'(INIT_LIVES);
            w_lost_nxt      = '0;
            w_grace_nxt     = '0;
            w_blink_cnt_nxt = '0;
            w_blink_on_nxt  = 1'b1;
        end else begin
            case (r_state)
                PLAY: begin
                    if (hitPulse && (bonusPulse || r_lives > CNT_W'(1))) begin
                        // A simultaneous bonus cancels the loss but still grants grace.
                        w_lives_nxt     = bonusPulse ? r_lives : r_lives - CNT_W'(1);
                        w_lost_nxt      = w_lives_nxt;
                        w_grace_nxt     = GRACE_W'(GRACE_FRAMES);
                        w_blink_cnt_nxt = '0;
                        w_blink_on_nxt  = 1'b0;
                        w_state_nxt     = GRACE;
                    end else if (hitPulse) begin
                        w_lives_nxt = '0;
                        w_state_nxt = GAME_OVER;
                    end else if (bonusPulse) begin
                        w_lives_nxt = sat_inc(r_lives);
                    end
                end
                GRACE: begin
                    if (bonusPulse) begin
                        w_lives_nxt = sat_inc(r_lives);
                    end
                    if (startOfFrame) begin
                        if (r_grace_cnt <= GRACE_W'(1)) begin
                            w_grace_nxt = '0;
                            w_state_nxt = PLAY;
                        end else begin
                            w_grace_nxt = r_grace_cnt - GRACE_W'(1);
                        end
                        if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                            w_blink_cnt_nxt = '0;
                            w_blink_on_nxt  = !r_blink_on;
                        end else begin
                            w_blink_cnt_nxt = r_blink_cnt + BLINK_W'(1);
                        end
                    end
                end
                GAME_OVER: begin
                    w_state_nxt = GAME_OVER;
                end
                default: begin
                    w_state_nxt = PLAY;
                end
            endcase
        end
    end

    always_comb begin
        w_inv_nxt = (w_state_nxt == GRACE);
        w_go_nxt  = (w_state_nxt == GAME_OVER);
    end

    lives_thermo_enc #(
        .MAX_LIVES (MAX_LIVES),
        .CNT_W     (CNT_W)
    ) u_thermo (
        .i_count    (w_lives_nxt),
        .i_lost_idx (w_lost_nxt),
        .i_blink_on (w_blink_on_nxt),
        .i_grace    (w_inv_nxt),
        .o_enable   (w_enable_nxt)
    );

    assign livesCount   = r_lives;
    assign enableLives  = r_enable;
    assign invulnerable = r_invulnerable;
    assign gameOver     = r_game_over;

endmodule

// File: tb/tb_lives_manager.sv
// Bench for lives_manager: vector table, hand-written corner sequences and a
// randomized run against a frame-counting reference model.
module tb_lives_manager;

    localparam int MAXL  = 8;
    localparam int INITL = 3;
    localparam int GRACE = 4;
    localparam int BLINK = 2;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       newGame = 1'b0;
    logic       hitPulse = 1'b0;
    logic       bonusPulse = 1'b0;
    logic [3:0] livesCount;
    logic [7:0] enableLives;
    logic       invulnerable;
    logic       gameOver;

    int n_checks = 0;
    int n_errors = 0;

    lives_manager #(
        .MAX_LIVES    (MAXL),
        .INIT_LIVES   (INITL),
        .GRACE_FRAMES (GRACE),
        .BLINK_FRAMES (BLINK)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .newGame      (newGame),
        .hitPulse     (hitPulse),
        .bonusPulse   (bonusPulse),
        .livesCount   (livesCount),
        .enableLives  (enableLives),
        .invulnerable (invulnerable),
        .gameOver     (gameOver)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model: mode 0=play 1=grace 2=over; blink phase derived from frames elapsed.
    int m_lives, m_mode, m_elapsed, m_lost;

    task automatic model_reset();
        m_lives = INITL; m_mode = 0; m_elapsed = 0; m_lost = 0;
    endtask

    task automatic model_step(input bit sof, input bit ng, input bit hit, input bit bon);
        if (ng) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (hit && bon) begin
                m_lost = m_lives; m_mode = 1; m_elapsed = 0;
            end else if (hit && m_lives > 1) begin
                m_lives--; m_lost = m_lives; m_mode = 1; m_elapsed = 0;
            end else if (hit) begin
                m_lives = 0; m_mode = 2;
            end else if (bon) begin
                m_lives = (m_lives < MAXL) ? m_lives + 1 : MAXL;
            end
        end else if (m_mode == 1) begin
            if (bon) m_lives = (m_lives < MAXL) ? m_lives + 1 : MAXL;
            if (sof) begin
                m_elapsed++;
                if (m_elapsed == GRACE) m_mode = 0;
            end
        end
    endtask

    function automatic int model_enable();
        int e;
        bit blink_on;
        e = 0;
        blink_on = ((m_elapsed / BLINK) % 2) == 1;
        for (int i = 0; i < MAXL; i++) begin
            if (i < m_lives || (m_mode == 1 && i == m_lost && m_lost >= m_lives && blink_on))
                e |= (1 << i);
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int lives, input int en, input int inv, input int go);
        chk({tag, ".lives"}, int'(livesCount), lives);
        chk({tag, ".enable"}, int'(enableLives), en);
        chk({tag, ".inv"}, int'(invulnerable), inv);
        chk({tag, ".gameOver"}, int'(gameOver), go);
    endtask

    // Apply one cycle of input pulses; returns #1 after the capturing edge.
    task automatic tick(input bit sof, input bit ng, input bit hit, input bit bon);
        startOfFrame = sof; newGame = ng; hitPulse = hit; bonusPulse = bon;
        @(posedge clk);
        #1;
        startOfFrame = 0; newGame = 0; hitPulse = 0; bonusPulse = 0;
        model_step(sof, ng, hit, bon);
    endtask

    typedef struct {
        bit sof, ng, hit, bon;
        int lives, en, inv, go;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit sof, input bit ng, input bit hit, input bit bon,
                       input int lives, input int en, input int inv, input int go);
        vec_t v;
        v.sof = sof; v.ng = ng; v.hit = hit; v.bon = bon;
        v.lives = lives; v.en = en; v.inv = inv; v.go = go;
        tbl.push_back(v);
    endtask

    initial begin
        // Idle frames, first hit with blink and grace expiry
        for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 3, 'h07, 0, 0);
        add(0, 0, 1, 0, 2, 'h03, 1, 0);
        add(1, 0, 0, 0, 2, 'h03, 1, 0);
        add(1, 0, 0, 0, 2, 'h07, 1, 0);
        add(1, 0, 0, 0, 2, 'h07, 1, 0);
        add(1, 0, 0, 0, 2, 'h03, 0, 0);
        // Hit ignored in grace, bonus in grace makes lost icon solid
        add(0, 0, 1, 0, 1, 'h01, 1, 0);
        add(0, 0, 1, 0, 1, 'h01, 1, 0);
        add(0, 0, 0, 1, 2, 'h03, 1, 0);
        add(1, 0, 0, 0, 2, 'h03, 1, 0);
        add(1, 0, 0, 0, 2, 'h03, 1, 0);
        add(1, 0, 0, 0, 2, 'h03, 1, 0);
        add(1, 0, 0, 0, 2, 'h03, 0, 0);
        // Bonus saturation
        add(0, 1, 0, 0, 3, 'h07, 0, 0);
        add(0, 0, 0, 1, 4, 'h0F, 0, 0);
        add(0, 0, 0, 1, 5, 'h1F, 0, 0);
        add(0, 0, 0, 1, 6, 'h3F, 0, 0);
        add(0, 0, 0, 1, 7, 'h7F, 0, 0);
        add(0, 0, 0, 1, 8, 'hFF, 0, 0);
        add(0, 0, 0, 1, 8, 'hFF, 0, 0);
        // Hits down to game over, then inert until newGame
        add(0, 1, 0, 0, 3, 'h07, 0, 0);
        add(0, 0, 1, 0, 2, 'h03, 1, 0);
        add(1, 0, 0, 0, 2, 'h03, 1, 0);
        add(1, 0, 0, 0, 2, 'h07, 1, 0);
        add(1, 0, 0, 0, 2, 'h07, 1, 0);
        add(1, 0, 0, 0, 2, 'h03, 0, 0);
        add(0, 0, 1, 0, 1, 'h01, 1, 0);
        add(1, 0, 0, 0, 1, 'h01, 1, 0);
        add(1, 0, 0, 0, 1, 'h03, 1, 0);
        add(1, 0, 0, 0, 1, 'h03, 1, 0);
        add(1, 0, 0, 0, 1, 'h01, 0, 0);
        add(0, 0, 1, 0, 0, 'h00, 0, 1);
        add(0, 0, 0, 1, 0, 'h00, 0, 1);
        add(0, 0, 1, 0, 0, 'h00, 0, 1);
        add(1, 0, 0, 0, 0, 'h00, 0, 1);
        add(0, 0, 1, 1, 0, 'h00, 0, 1);
        add(0, 1, 0, 0, 3, 'h07, 0, 0);

        // Reset state
        model_reset();
        #1 resetN = 1'b0;
        #1 chk_all("reset", 3, 'h07, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 resetN = 1'b1;
        chk_all("reset_hold", 3, 'h07, 0, 0);

        foreach (tbl[k]) begin
            tick(tbl[k].sof, tbl[k].ng, tbl[k].hit, tbl[k].bon);
            chk_all($sformatf("vec%0d", k), tbl[k].lives, tbl[k].en, tbl[k].inv, tbl[k].go);
        end

        // Hit coinciding with a frame tick: the full grace window still follows
        tick(1, 0, 1, 0);
        chk_all("hit_sof", 2, 'h03, 1, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("hit_sof.3frames.inv", int'(invulnerable), 1);
        tick(1, 0, 0, 0);
        chk_all("hit_sof.expired", 2, 'h03, 0, 0);

        // From one life, simultaneous hit and bonus grants grace without game over
        tick(0, 0, 1, 0);
        for (int i = 0; i < GRACE; i++) tick(1, 0, 0, 0);
        chk_all("one_life", 1, 'h01, 0, 0);
        tick(0, 0, 1, 1);
        chk_all("hit_bonus", 1, 'h01, 1, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk_all("hit_bonus.blink", 1, 'h03, 1, 0);

        // Asynchronous reset in the middle of grace
        resetN = 1'b0;
        model_reset();
        #1 chk_all("async_reset", 3, 'h07, 0, 0);
        @(posedge clk);
        #1 resetN = 1'b1;
        tick(1, 0, 0, 0);
        chk_all("after_reset", 3, 'h07, 0, 0);

        // Randomized run against the reference model
        for (int c = 0; c < 2000; c++) begin
            bit sof, ng, hit, bon;
            sof = ($urandom_range(0, 3) == 0);
            ng  = ($urandom_range(0, 99) == 0);
            hit = ($urandom_range(0, 5) == 0);
            bon = ($urandom_range(0, 6) == 0);
            tick(sof, ng, hit, bon);
            chk_all($sformatf("rnd%0d", c), m_lives, model_enable(), (m_mode == 1) ? 1 : 0,
                    (m_mode == 2) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
